uart_cmd_controller: RTL and testbench

Frame-level controller behind the UART receive path. It consumes bytes from the 8N1 receiver's `data_ready`/`data_out` strobe and assembles 4-byte command frames: SYNC, ADDR, DATA, CHK. It validates each frame and issues one register write per good frame over a valid/ready handshake. It also detects malformed frames, overruns and stalled frames, reports them, and resynchronises to the next SYNC byte.

---
 rtl/uart_cmd_controller.sv | 148 ++++++++++++++
 tb/tb_uart_cmd_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_controller.sv
// rtl/uart_cmd_controller.sv - UART command frame controller (SYNC/ADDR/DATA/CHK -> register write)
// Optional inter-byte timeout is built only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_controller #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] err_count,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_ISSUE
    } state_t;

    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_OVERRUN  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       wr_valid_q;
    logic       frame_err_q;
    logic [1:0] err_code_q;
    logic [7:0] err_count_q;
    logic       busy_q;
    logic       err_d;
    logic [1:0] err_code_d;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q;
    logic          timed_state;
    logic          tmo_expired;

    assign timed_state = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign tmo_expired = timed_state && !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        case (state_q)
            ST_SYNC: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    data_d  = rx_data;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                // A failing checksum byte is never reinterpreted as a new SYNC.
                if (rx_valid) begin
                    if (rx_data == (SYNC_BYTE ^ addr_q ^ data_q)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d    = ST_SYNC;
                        err_d      = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end
            ST_ISSUE: begin
                if (wr_ready) begin
                    state_d = (rx_valid && rx_data == SYNC_BYTE) ? ST_ADDR : ST_SYNC;
                end else if (rx_valid) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
            end
            default: state_d = ST_SYNC;
        endcase
`ifdef UART_CMD_TIMEOUT_EN
        if (tmo_expired) begin
            state_d    = ST_SYNC;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
`endif
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_count_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_valid_q  <= (state_d == ST_ISSUE);
            frame_err_q <= err_d;
            err_code_q  <= err_code_d;
            busy_q      <= (state_d != ST_SYNC);
            if (err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'h01;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    // Counter restarts on every byte and on every state change into a timed state.
    always_ff @(posedge clk_50MHz) begin
        if (reset || rx_valid || !timed_state || state_d != state_q) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`endif

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// tb/tb_uart_cmd_controller.sv - scoreboard bench for uart_cmd_controller
module tb_uart_cmd_controller;

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b1;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       wr_ready  = 1'b0;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_count;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_wr_q[$];
    logic [1:0]  exp_err_q[$];

    uart_cmd_controller #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .frame_err (frame_err),
        .err_code  (err_code),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5);
        send(a);
        send(d);
        send(c);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_valid"}, wr_valid, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: inputs change 2 time units after posedge, so the negedge sees settled values.
    always @(negedge clk_50MHz) begin
        if (!reset) begin
            if (wr_valid && wr_ready) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got %02h/%02h expected none", wr_addr, wr_data);
                end else begin
                    check("write_addr_data", {wr_addr, wr_data}, exp_wr_q.pop_front());
                end
            end
            if (frame_err) begin
                if (exp_err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_error: got code %0d expected none", err_code);
                end else begin
                    check("error_code", err_code, exp_err_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;
        step();

        // Good frame: A5^12^34 = 83
        wr_ready = 1'b1;
        exp_wr_q.push_back(16'h1234);
        send_frame(8'h12, 8'h34, 8'h83);
        check("good_latency_wr_valid", wr_valid, 1);
        check("good_busy", busy, 1);
        step();
        check("good_single_cycle", wr_valid, 0);
        check("good_busy_falls", busy, 0);
        check("good_err_count", err_count, 0);

        // Bad checksum, then a good frame (A5^56^78 = 8B)
        exp_err_q.push_back(2'b01);
        send_frame(8'h12, 8'h34, 8'h00);
        check("chk_frame_err", frame_err, 1);
        step();
        check("chk_pulse_one_cycle", frame_err, 0);
        check("chk_err_code", err_code, 2'b01);
        check("chk_err_count", err_count, 1);
        check("chk_no_write", wr_valid, 0);
        exp_wr_q.push_back(16'h5678);
        send_frame(8'h56, 8'h78, 8'h8B);
        step();
        step();

        // Overrun while stalled
        wr_ready = 1'b0;
        exp_wr_q.push_back(16'h1234);
        send_frame(8'h12, 8'h34, 8'h83);
        repeat (20) step();
        exp_err_q.push_back(2'b10);
        send(8'h55);
        check("ovr_err_code", err_code, 2'b10);
        check("ovr_err_count", err_count, 2);
        check("ovr_wr_valid_held", wr_valid, 1);
        check("ovr_addr_data_held", {wr_addr, wr_data}, 16'h1234);
        wr_ready = 1'b1;
        step();
        check("ovr_released", wr_valid, 0);
        check("ovr_err_code_holds", err_code, 2'b10);

        // SYNC byte arriving in the accepting ISSUE cycle (A5^9A^BC = 83, A5^01^02 = A6)
        exp_wr_q.push_back(16'h9ABC);
        send_frame(8'h9A, 8'hBC, 8'h83);
        send(8'hA5);
        check("overlap_busy", busy, 1);
        check("overlap_wr_valid_low", wr_valid, 0);
        check("overlap_no_error", err_count, 2);
        exp_wr_q.push_back(16'h0102);
        send(8'h01);
        send(8'h02);
        send(8'hA6);
        check("overlap_next_write", wr_valid, 1);
        step();
        step();

        // Inter-byte timeout
        send(8'hA5);
        send(8'h12);
`ifdef UART_CMD_TIMEOUT_EN
        exp_err_q.push_back(2'b11);
        n = 0;
        while (!frame_err && n < 200) begin
            step();
            n++;
        end
        check("tmo_cycles", n, 100);
        check("tmo_err_code", err_code, 2'b11);
        check("tmo_err_count", err_count, 3);
        check("tmo_busy", busy, 0);
`else
        n = 0;
        repeat (200) step();
        check("notmo_busy", busy, 1);
        check("notmo_err_count", err_count, 2);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("reset2");

        // Saturation over 300 bad frames
        for (int i = 0; i < 300; i++) begin
            exp_err_q.push_back(2'b01);
            send_frame(8'h00, 8'h00, 8'h00);
        end
        step();
        check("sat_err_count", err_count, 255);
        check("sat_err_code", err_code, 2'b01);

        // Reset mid-frame; trailing bytes are then discarded in SYNC
        send(8'hA5);
        send(8'h12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("midreset");
        send(8'h34);
        send(8'h83);
        repeat (5) step();
        check("midreset_no_write", wr_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_no_error", err_count, 0);

        check("pending_writes", exp_wr_q.size(), 0);
        check("pending_errors", exp_err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
